seg7_scan_driver: RTL and testbench

- Parametrised successor to the single-digit 5-bit-code to 7-segment decoder.
- Drives N time-multiplexed digits from one shared segment bus.
- Decodes the full 32-code glyph set, with per-digit blanking and a configurable anti-ghosting gap.
- Double-buffers display codes so a frame never shows a partial update. Sits between the register/control logic and the board's display pins.

---
 rtl/seg7_scan_driver.sv | 254 +++++++++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed driver for N seven-segment digits that share one segment bus.
// Each digit is lit for REFRESH_DIV cycles and is followed by GAP_CYCLES all-off
// cycles, which suppress ghosting while the segment bus changes glyphs. Display
// codes are double-buffered. A new set of codes only becomes visible at the frame
// wrap, so a frame never shows a half-updated value.
// Every output is registered. The outputs reflect the internal scan state with one
// cycle of latency.

module seg7_scan_driver #(
   parameter int N_DIGITS       = 4,      // multiplexed digits, 1..16
   parameter int REFRESH_DIV    = 50000,  // cycles each digit is lit, >= 1
   parameter int GAP_CYCLES     = 2,      // all-off cycles between digits, 0 = none
   parameter int SEG_ACTIVE_LOW = 0,      // 1 = invert segment outputs
   parameter int AN_ACTIVE_LOW  = 0       // 1 = invert digit-select outputs
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    load,
   input  logic [5*N_DIGITS-1:0]   codes_in,
   input  logic [N_DIGITS-1:0]     blank_mask,
   output logic [6:0]              seg,
   output logic [N_DIGITS-1:0]     an,
   output logic                    frame_tick
);

   // ------------------------------------------------------------------------
   // Derived sizes and constants
   // ------------------------------------------------------------------------
   localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);
   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam bit               HAS_GAP   = (GAP_CYCLES > 0);

   // The polarity masks are XORed onto the raw active-high values. Therefore
   // "inactive" is the mask itself.
   localparam logic [6:0]          SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [N_DIGITS-1:0] AN_INV  = (AN_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : '0;

   localparam logic [4:0] CODE_BLANK = 5'h1F;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   // ------------------------------------------------------------------------
   // Glyph table: 5-bit code to raw active-high {A,B,C,D,E,F,G}
   // ------------------------------------------------------------------------
   function automatic logic [6:0] glyph(input logic [4:0] code);
      logic [6:0] g;
      case (code)
         5'h00:   g = 7'b1111110;
         5'h01:   g = 7'b0110000;
         5'h02:   g = 7'b1101101;
         5'h03:   g = 7'b1111001;
         5'h04:   g = 7'b0110011;
         5'h05:   g = 7'b1011011;
         5'h06:   g = 7'b1011111;
         5'h07:   g = 7'b1110000;
         5'h08:   g = 7'b1111111;
         5'h09:   g = 7'b1111011;
         5'h0A:   g = 7'b1110111;
         5'h0B:   g = 7'b0011111;
         5'h0C:   g = 7'b1001110;
         5'h0D:   g = 7'b0111101;
         5'h0E:   g = 7'b1001111;
         5'h0F:   g = 7'b1000111;
         5'h10:   g = 7'b0000001;  // '-'
         5'h11:   g = 7'b0110111;  // 'H'
         5'h12:   g = 7'b0001110;  // 'L'
         5'h13:   g = 7'b1100111;  // 'P'
         5'h14:   g = 7'b0111110;  // 'U'
         5'h15:   g = 7'b0000101;  // 'r'
         5'h16:   g = 7'b0010101;  // 'n'
         5'h17:   g = 7'b0011101;  // 'o'
         default: g = 7'b0000000;  // 18..1F are blank
      endcase
      return g;
   endfunction

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    wrap_pend_q, wrap_pend_d;   // a wrap has happened and its frame_tick is still owed

   logic [5*N_DIGITS-1:0]   active_q, active_d;          // codes currently on display
   logic [5*N_DIGITS-1:0]   pending_q, pending_d;        // codes waiting for the next wrap
   logic                    pend_valid_q, pend_valid_d;

   logic [6:0]              seg_q, seg_d;
   logic [N_DIGITS-1:0]     an_q, an_d;
   logic                    tick_q, tick_d;

   logic                    wrap_event;                  // idx moving from the last digit back to 0
   logic [4:0]              act_code [N_DIGITS];
   logic [4:0]              cur_code;
   logic [N_DIGITS-1:0]     an_raw;

   // Register every piece of state. Synchronous reset takes priority over all other updates.
   // NOTE: sequential state uses non-blocking (<=) only. Other always blocks therefore
   // see the pre-edge value.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         cnt_q        <= '0;
         wrap_pend_q  <= 1'b0;
         // NOTE: the code buffers are reset on purpose. After reset every digit must
         // read as blank (1F), and stale pending data must never reach the display.
         active_q     <= {N_DIGITS{CODE_BLANK}};
         pending_q    <= '0;
         pend_valid_q <= 1'b0;
         seg_q        <= SEG_INV;
         an_q         <= AN_INV;
         tick_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         wrap_pend_q  <= wrap_pend_d;
         active_q     <= active_d;
         pending_q    <= pending_d;
         pend_valid_q <= pend_valid_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
         tick_q       <= tick_d;
      end
   end

   // Scan sequencer: IDLE -> SCAN (lit window) -> GAP (all off) -> SCAN, with digit index advance.
   // NOTE: every signal driven here gets a default first. Otherwise a path that
   // leaves a signal unassigned would infer a latch.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      wrap_event = 1'b0;

      if (!en) begin
         state_d = ST_IDLE;
         idx_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_SCAN;
               idx_d   = '0;
               cnt_d   = '0;
            end

            ST_SCAN: begin
               if (cnt_q == SCAN_LAST) begin
                  cnt_d      = '0;
                  wrap_event = (idx_q == IDX_LAST);
                  idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                  state_d    = HAS_GAP ? ST_GAP : ST_SCAN;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end

            ST_GAP: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_SCAN;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end

            default: begin
               state_d = ST_IDLE;
               idx_d   = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Double buffer. In IDLE a load goes straight to active. Otherwise it waits in
   // pending until the wrap. A load on the wrap cycle itself bypasses pending.
   always_comb begin
      active_d     = active_q;
      pending_d    = pending_q;
      pend_valid_d = pend_valid_q;

      if (state_q == ST_IDLE && load) begin
         active_d     = codes_in;
         pend_valid_d = 1'b0;
      end else if (wrap_event) begin
         if (load) begin
            active_d = codes_in;
         end else if (pend_valid_q) begin
            active_d = pending_q;
         end
         pend_valid_d = 1'b0;
      end else if (load) begin
         pending_d    = codes_in;
         pend_valid_d = 1'b1;
      end
   end

   // Unpacked view of the active codes, so the current digit can be selected by index.
   always_comb begin
      for (int k = 0; k < N_DIGITS; k++) begin
         act_code[k] = active_q[5*k +: 5];
      end
   end

   // Next output values from the current scan position. Outputs are lit only in SCAN
   // while enabled. frame_tick is owed only after a wrap, never on the first entry
   // from IDLE.
   always_comb begin
      seg_d    = SEG_INV;
      an_d     = AN_INV;
      an_raw   = '0;
      tick_d   = 1'b0;
      cur_code = act_code[idx_q];

      if (en && state_q == ST_SCAN) begin
         an_raw[idx_q] = 1'b1;
         an_d          = an_raw ^ AN_INV;
         seg_d         = (blank_mask[idx_q] ? 7'b0000000 : glyph(cur_code)) ^ SEG_INV;
         tick_d        = wrap_pend_q && (idx_q == '0) && (cnt_q == '0);
      end
   end

   // Remember that a wrap occurred, until digit 0 of the new frame is first shown.
   always_comb begin
      wrap_pend_d = wrap_pend_q;
      if (!en || state_q == ST_IDLE) begin
         wrap_pend_d = 1'b0;
      end else if (wrap_event) begin
         wrap_pend_d = 1'b1;
      end else if (tick_d) begin
         wrap_pend_d = 1'b0;
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver.
// Two instances run with N_DIGITS=4, REFRESH_DIV=4 and GAP_CYCLES=1. One is
// active-high and the other has both outputs inverted. They share all inputs.
// A frame-position model predicts the raw outputs each cycle, and each instance's
// polarity is applied to that prediction.

module tb_seg7_scan_driver;

   localparam int N  = 4;
   localparam int R  = 4;
   localparam int G  = 1;
   localparam int SL = R + G;     // slot length per digit
   localparam int P  = N * SL;    // frame period

   localparam logic [6:0] GLYPH [32] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111,
      7'b0000001, 7'b0110111, 7'b0001110, 7'b1100111,
      7'b0111110, 7'b0000101, 7'b0010101, 7'b0011101,
      7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000,
      7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
   };

   logic             clk;
   logic             rst;
   logic             en;
   logic             load;
   logic [5*N-1:0]   codes_in;
   logic [N-1:0]     blank_mask;
   logic [6:0]       seg_a, seg_b;
   logic [N-1:0]     an_a, an_b;
   logic             tick_a, tick_b;

   int n_checks = 0;
   int n_fails  = 0;

   // Model: "running" means the scan is active, and t counts cycles since entering SCAN.
   bit               running;
   int               t;
   logic [4:0]       m_active [N];
   logic [4:0]       m_pend   [N];
   bit               m_pv;

   seg7_scan_driver #(
      .N_DIGITS(N), .REFRESH_DIV(R), .GAP_CYCLES(G),
      .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)
   ) dut_a (
      .clk(clk), .rst(rst), .en(en), .load(load),
      .codes_in(codes_in), .blank_mask(blank_mask),
      .seg(seg_a), .an(an_a), .frame_tick(tick_a)
   );

   seg7_scan_driver #(
      .N_DIGITS(N), .REFRESH_DIV(R), .GAP_CYCLES(G),
      .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
   ) dut_b (
      .clk(clk), .rst(rst), .en(en), .load(load),
      .codes_in(codes_in), .blank_mask(blank_mask),
      .seg(seg_b), .an(an_b), .frame_tick(tick_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s at t=%0t: observed=%b expected=%b", tag, $time, obs, exp);
      end
   endtask

   // One clock. The expected outputs come from the model state and the inputs
   // before the edge. The model is then advanced, and the outputs are checked 1
   // time unit after the edge.
   task automatic step();
      logic [6:0]   e_seg;
      logic [N-1:0] e_an;
      logic         e_tick;
      int           p, d, w;
      e_seg  = '0;
      e_an   = '0;
      e_tick = 1'b0;

      if (rst) begin
         running = 0;
         t       = 0;
         m_pv    = 0;
         for (int k = 0; k < N; k++) m_active[k] = 5'h1F;
      end else if (!en) begin
         if (load) begin
            if (!running) begin
               for (int k = 0; k < N; k++) m_active[k] = codes_in[5*k +: 5];
               m_pv = 0;
            end else begin
               for (int k = 0; k < N; k++) m_pend[k] = codes_in[5*k +: 5];
               m_pv = 1;
            end
         end
         running = 0;
         t       = 0;
      end else if (!running) begin
         if (load) begin
            for (int k = 0; k < N; k++) m_active[k] = codes_in[5*k +: 5];
            m_pv = 0;
         end
         running = 1;
         t       = 0;
      end else begin
         p = t % P;
         d = p / SL;
         w = p % SL;
         if (w < R) begin
            e_an  = N'(1 << d);
            e_seg = blank_mask[d] ? 7'b0000000 : GLYPH[m_active[d]];
         end
         e_tick = (t > 0) && (p == 0);
         if (p == P - G - 1) begin
            if (load) begin
               for (int k = 0; k < N; k++) m_active[k] = codes_in[5*k +: 5];
            end else if (m_pv) begin
               for (int k = 0; k < N; k++) m_active[k] = m_pend[k];
            end
            m_pv = 0;
         end else if (load) begin
            for (int k = 0; k < N; k++) m_pend[k] = codes_in[5*k +: 5];
            m_pv = 1;
         end
         t++;
      end

      @(posedge clk);
      #1;
      check("seg_a",  seg_a,           e_seg);
      check("an_a",   {3'b000, an_a},  {3'b000, e_an});
      check("tick_a", {6'd0, tick_a},  {6'd0, e_tick});
      check("seg_b",  seg_b,           e_seg ^ 7'h7F);
      check("an_b",   {3'b000, an_b},  {3'b000, e_an ^ {N{1'b1}}});
      check("tick_b", {6'd0, tick_b},  {6'd0, e_tick});
   endtask

   // Advance until the next step() lands on the given frame position (bounded).
   task automatic wait_pos(input int target);
      int i;
      i = 0;
      while (!(running && (t % P) == target) && i < 4 * P) begin
         step();
         i++;
      end
      n_checks++;
      assert (running && (t % P) == target) else begin
         n_fails++;
         $error("FAIL wait_pos: position %0d not reached within %0d cycles", target, 4 * P);
      end
   endtask

   initial begin
      rst        = 1'b1;
      en         = 1'b0;
      load       = 1'b0;
      codes_in   = '0;
      blank_mask = '0;
      running    = 0;
      t          = 0;
      m_pv       = 0;
      for (int k = 0; k < N; k++) begin
         m_active[k] = 5'h1F;
         m_pend[k]   = 5'h00;
      end

      // Reset state
      step();
      step();
      rst = 1'b0;
      step();
      step();

      // Plain scan with reset codes: digit walk with gaps, all segments off
      en = 1'b1;
      repeat (2 * P + 5) step();

      // Load {3,A,11,1F} while idle, then scan
      en = 1'b0;
      step();
      codes_in = {5'h03, 5'h0A, 5'h11, 5'h1F};
      load = 1'b1;
      step();
      load = 1'b0;
      en   = 1'b1;
      repeat (2 * P + 5) step();

      // Mid-frame load at digit 1: digit 0 becomes 8 only after the wrap
      wait_pos(SL);
      codes_in = {5'h03, 5'h0A, 5'h11, 5'h08};
      load = 1'b1;
      step();
      load = 1'b0;
      repeat (P + 10) step();

      // Two loads in one frame: only the second reaches the display
      wait_pos(2);
      codes_in = {5'h03, 5'h0A, 5'h11, 5'h00};
      load = 1'b1;
      step();
      load = 1'b0;
      wait_pos(2 * SL + 1);
      codes_in = {5'h03, 5'h0A, 5'h11, 5'h09};
      load = 1'b1;
      step();
      load = 1'b0;
      repeat (P + 10) step();

      // Load on the exact wrap cycle: shown in the same new frame
      wait_pos(P - G - 1);
      codes_in = {5'h03, 5'h0A, 5'h11, 5'h10};
      load = 1'b1;
      step();
      load = 1'b0;
      repeat (P + 5) step();

      // All eights with digit 2 blanked live
      codes_in = {5'h08, 5'h08, 5'h08, 5'h08};
      load = 1'b1;
      step();
      load = 1'b0;
      wait_pos(0);
      blank_mask = 4'b0100;
      repeat (2 * P) step();
      blank_mask = 4'b0000;

      // Reset during digit 2 with a pending load. The restart shows blanks and no tick.
      wait_pos(2 * SL + 1);
      codes_in = {5'h01, 5'h02, 5'h03, 5'h04};
      load = 1'b1;
      step();
      load = 1'b0;
      rst  = 1'b1;
      step();
      rst  = 1'b0;
      repeat (P + 5) step();

      // Drop en during a gap, then re-enable
      wait_pos(SL + R);
      en = 1'b0;
      step();
      step();
      en = 1'b1;
      repeat (P + 5) step();

      // Randomised traffic
      repeat (1500) begin
         rst        = ($urandom_range(0, 299) == 0);
         en         = ($urandom_range(0, 39) != 0);
         load       = ($urandom_range(0, 7) == 0);
         codes_in   = 20'($urandom);
         blank_mask = 4'($urandom);
         step();
      end
      rst  = 1'b0;
      load = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
